// File: rtl/clock24_set_ctrl_if.sv
// Handshake-free signal bundle between the 24 h clock set controller and its environment.
// master drives time/buttons/DST, slave (the controller) drives load and display hints.
interface clock24_set_ctrl_if;
  logic [23:0] disp_time;
  logic        btn_mode;
  logic        btn_inc;
  logic        spring_szn;
  logic        load;
  logic [23:0] load_time;
  logic [1:0]  edit_field;
  logic        blink;

  modport master (
    output disp_time, btn_mode, btn_inc, spring_szn,
    input  load, load_time, edit_field, blink
  );

  modport slave (
    input  disp_time, btn_mode, btn_inc, spring_szn,
    output load, load_time, edit_field, blink
  );
endinterface

// File: rtl/clock24_set_ctrl.sv
// Time-setting and daylight-saving sequencer for a BCD HHMMSS clock; emits a one-cycle
// load pulse with the new time one cycle after the triggering edge, plus edit/blink hints.
module clock24_set_ctrl #(
  parameter int HOLD_CYCLES = 500,
  parameter int BLINK_DIV   = 250,
  parameter int TIMEOUT     = 10000
) (
  input logic               kh_clk,
  input logic               reset,
  clock24_set_ctrl_if.slave bus
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {RUN, SET_HR, SET_MIN, SET_SEC, COMMIT} state_t;

  state_t      state;
  logic [23:0] shadow;
  logic        mode_q, inc_q, szn_q, armed;
  logic [HW-1:0] hold_cnt;
  logic [BW-1:0] blink_cnt;
  logic [TW-1:0] tmo_cnt;

  logic        mode_rise, inc_rise, szn_rise, szn_fall;
  logic        hr_or_min, repeat_hit, inc_evt;
  logic [23:0] shadow_dst, shadow_upd;

  function automatic logic [7:0] hr_inc(input logic [7:0] h);
    if (h[7:4] > 4'd2 || h[3:0] > 4'd9 || (h[7:4] == 4'd2 && h[3:0] >= 4'd3))
      return 8'h00;
    else if (h[3:0] == 4'd9)
      return {h[7:4] + 4'd1, 4'd0};
    else
      return {h[7:4], h[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] hr_dec(input logic [7:0] h);
    if (h == 8'h00 || h[7:4] > 4'd2 || h[3:0] > 4'd9 || (h[7:4] == 4'd2 && h[3:0] > 4'd3))
      return 8'h23;
    else if (h[3:0] == 4'd0)
      return {h[7:4] - 4'd1, 4'd9};
    else
      return {h[7:4], h[3:0] - 4'd1};
  endfunction

  function automatic logic [7:0] min_inc(input logic [7:0] m);
    if (m[7:4] > 4'd5 || m[3:0] > 4'd9 || m == 8'h59)
      return 8'h00;
    else if (m[3:0] == 4'd9)
      return {m[7:4] + 4'd1, 4'd0};
    else
      return {m[7:4], m[3:0] + 4'd1};
  endfunction

  // armed gates edges so the first cycle out of reset only samples the levels
  assign mode_rise  = armed & bus.btn_mode & ~mode_q;
  assign inc_rise   = armed & bus.btn_inc & ~inc_q;
  assign szn_rise   = armed & bus.spring_szn & ~szn_q;
  assign szn_fall   = armed & ~bus.spring_szn & szn_q;
  assign hr_or_min  = (state == SET_HR) || (state == SET_MIN);
  assign repeat_hit = hr_or_min & bus.btn_inc & ~inc_rise & (hold_cnt == HW'(HOLD_CYCLES - 1));
  assign inc_evt    = inc_rise | repeat_hit;

  always_comb begin
    shadow_dst = shadow;
    if (szn_rise)
      shadow_dst[23:16] = hr_inc(shadow[23:16]);
    else if (szn_fall)
      shadow_dst[23:16] = hr_dec(shadow[23:16]);
  end

  always_comb begin
    shadow_upd = shadow_dst;
    if (inc_evt && !mode_rise) begin
      case (state)
        SET_HR:  shadow_upd[23:16] = hr_inc(shadow_dst[23:16]);
        SET_MIN: shadow_upd[15:8]  = min_inc(shadow_dst[15:8]);
        SET_SEC: shadow_upd[7:0]   = 8'h00;
        default: shadow_upd = shadow_dst;
      endcase
    end
  end

  always_ff @(posedge kh_clk or negedge reset) begin
    if (!reset) begin
      state          <= RUN;
      shadow         <= '0;
      mode_q         <= 1'b0;
      inc_q          <= 1'b0;
      szn_q          <= 1'b0;
      armed          <= 1'b0;
      hold_cnt       <= '0;
      blink_cnt      <= '0;
      tmo_cnt        <= '0;
      bus.load       <= 1'b0;
      bus.load_time  <= '0;
      bus.edit_field <= 2'd0;
      bus.blink      <= 1'b0;
    end else begin
      mode_q   <= bus.btn_mode;
      inc_q    <= bus.btn_inc;
      szn_q    <= bus.spring_szn;
      armed    <= 1'b1;
      bus.load <= 1'b0;

      if (!bus.btn_inc || inc_rise || mode_rise || !hr_or_min || repeat_hit)
        hold_cnt <= '0;
      else
        hold_cnt <= hold_cnt + 1'b1;

      case (state)
        RUN: begin
          bus.edit_field <= 2'd0;
          bus.blink      <= 1'b0;
          // A DST edge right behind a load is dropped so load never stays high two cycles
          if ((szn_rise || szn_fall) && !bus.load) begin
            bus.load      <= 1'b1;
            bus.load_time <= {szn_rise ? hr_inc(bus.disp_time[23:16]) : hr_dec(bus.disp_time[23:16]),
                              bus.disp_time[15:0]};
          end else if (mode_rise) begin
            state          <= SET_HR;
            shadow         <= bus.disp_time;
            bus.edit_field <= 2'd1;
            bus.blink      <= 1'b1;
            blink_cnt      <= '0;
            tmo_cnt        <= '0;
          end
        end

        SET_HR, SET_MIN, SET_SEC: begin
          shadow <= shadow_upd;
          if (mode_rise) begin
            tmo_cnt   <= '0;
            blink_cnt <= '0;
            bus.blink <= 1'b1;
            case (state)
              SET_HR: begin
                state          <= SET_MIN;
                bus.edit_field <= 2'd2;
              end
              SET_MIN: begin
                state          <= SET_SEC;
                bus.edit_field <= 2'd3;
              end
              default: begin
                state          <= COMMIT;
                bus.edit_field <= 2'd0;
                bus.blink      <= 1'b0;
                bus.load       <= 1'b1;
                bus.load_time  <= shadow_dst;
              end
            endcase
          end else if (!inc_rise && tmo_cnt == TW'(TIMEOUT - 1)) begin
            state          <= RUN;
            bus.edit_field <= 2'd0;
            bus.blink      <= 1'b0;
          end else begin
            tmo_cnt <= inc_rise ? '0 : tmo_cnt + 1'b1;
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
              blink_cnt <= '0;
              bus.blink <= ~bus.blink;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end

        default: begin
          state          <= RUN;
          bus.edit_field <= 2'd0;
          bus.blink      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock24_set_ctrl.sv
// Bench for clock24_set_ctrl: directed button/DST sequences push expected load_time values,
// a negedge monitor pops and compares on every load pulse.
module tb_clock24_set_ctrl;

  localparam int HOLD  = 500;
  localparam int BLINK = 250;
  localparam int TMO   = 10000;

  logic kh_clk = 1'b0;
  logic reset  = 1'b0;
  int   tests  = 0;
  int   fails  = 0;
  logic [23:0] exp_q[$];
  logic        prev_load = 1'b0;

  clock24_set_ctrl_if bus ();

  clock24_set_ctrl #(.HOLD_CYCLES(HOLD), .BLINK_DIV(BLINK), .TIMEOUT(TMO)) dut (
    .kh_clk (kh_clk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 kh_clk = ~kh_clk;

  always @(negedge kh_clk) begin
    if (bus.load) begin
      tests++;
      if (prev_load) begin
        fails++;
        $display("FAIL load_consecutive: load high two cycles in a row at %0t", $time);
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_load: got load_time=%06h, expected no load at %0t", bus.load_time, $time);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if (bus.load_time !== e) begin
          fails++;
          $display("FAIL load_time: got %06h, expected %06h at %0t", bus.load_time, e, $time);
        end
      end
    end
    prev_load = bus.load;
  end

  task automatic tick();
    @(posedge kh_clk);
    #2;
  endtask

  task automatic press_mode();
    bus.btn_mode = 1'b1;
    tick();
    bus.btn_mode = 1'b0;
    tick();
  endtask

  task automatic press_inc();
    bus.btn_inc = 1'b1;
    tick();
    bus.btn_inc = 1'b0;
    tick();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  initial begin
    bus.disp_time  = 24'h000000;
    bus.btn_mode   = 1'b0;
    bus.btn_inc    = 1'b0;
    bus.spring_szn = 1'b0;
    #23;
    check("reset_load_time", 32'(bus.load_time), 32'h0);
    check("reset_edit_field", 32'(bus.edit_field), 32'd0);
    reset = 1'b1;

    // 1: idle after reset
    repeat (20) tick();
    check("idle_load", 32'(bus.load), 32'd0);
    check("idle_edit_field", 32'(bus.edit_field), 32'd0);
    check("idle_blink", 32'(bus.blink), 32'd0);
    check("idle_load_time", 32'(bus.load_time), 32'h0);

    // 2: full edit with hour and minute wraps
    bus.disp_time = 24'h235940;
    press_mode();
    check("t2_field_hr", 32'(bus.edit_field), 32'd1);
    check("t2_blink_entry", 32'(bus.blink), 32'd1);
    repeat (2) press_inc();
    press_mode();
    check("t2_field_min", 32'(bus.edit_field), 32'd2);
    repeat (3) press_inc();
    press_mode();
    check("t2_field_sec", 32'(bus.edit_field), 32'd3);
    press_inc();
    exp_q.push_back(24'h010200);
    press_mode();
    check("t2_field_after_commit", 32'(bus.edit_field), 32'd0);
    check("t2_load_consumed", 32'(exp_q.size()), 32'd0);

    // 3: DST in RUN, both directions with wrap
    repeat (3) tick();
    bus.disp_time = 24'h231507;
    exp_q.push_back(24'h001507);
    bus.spring_szn = 1'b1;
    tick();
    check("t3_spring_load_next_cycle", 32'(bus.load), 32'd1);
    repeat (4) tick();
    bus.disp_time = 24'h002000;
    exp_q.push_back(24'h232000);
    bus.spring_szn = 1'b0;
    repeat (4) tick();
    check("t3_dst_consumed", 32'(exp_q.size()), 32'd0);

    // 4: auto-repeat in SET_HR
    bus.disp_time = 24'h105000;
    press_mode();
    bus.btn_inc = 1'b1;
    repeat (3 * HOLD + 5) tick();
    bus.btn_inc = 1'b0;
    tick();
    check("t4_no_load_before_commit", 32'(exp_q.size()), 32'd0);
    press_mode();
    press_mode();
    exp_q.push_back(24'h145000);
    press_mode();
    check("t4_load_consumed", 32'(exp_q.size()), 32'd0);

    // 5: blink phase and timeout in SET_MIN
    bus.disp_time = 24'h120000;
    press_mode();
    press_mode();
    check("t5_field_min", 32'(bus.edit_field), 32'd2);
    check("t5_blink_entry", 32'(bus.blink), 32'd1);
    repeat (BLINK - 2) tick();
    check("t5_blink_before_toggle", 32'(bus.blink), 32'd1);
    tick();
    check("t5_blink_toggled", 32'(bus.blink), 32'd0);
    repeat (TMO - BLINK - 1) tick();
    check("t5_still_editing", 32'(bus.edit_field), 32'd2);
    tick();
    check("t5_timeout_field", 32'(bus.edit_field), 32'd0);
    check("t5_timeout_blink", 32'(bus.blink), 32'd0);

    // DST inside SET_HR adjusts shadow only
    bus.disp_time = 24'h000500;
    press_mode();
    bus.spring_szn = 1'b1;
    repeat (3) tick();
    check("dst_set_no_load", 32'(bus.edit_field), 32'd1);
    press_mode();
    press_mode();
    exp_q.push_back(24'h010500);
    press_mode();

    // 6: simultaneous mode+inc, then reset mid-edit
    bus.disp_time = 24'h080000;
    press_mode();
    bus.btn_mode = 1'b1;
    bus.btn_inc  = 1'b1;
    tick();
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    tick();
    check("t6_mode_wins", 32'(bus.edit_field), 32'd2);
    press_mode();
    exp_q.push_back(24'h080000);
    press_mode();
    press_mode();
    press_mode();
    press_inc();
    check("t6_in_set_min", 32'(bus.edit_field), 32'd2);
    reset = 1'b0;
    #1;
    check("t6_reset_field", 32'(bus.edit_field), 32'd0);
    check("t6_reset_load", 32'(bus.load), 32'd0);
    tick();
    reset = 1'b1;
    repeat (20) tick();
    check("t6_after_reset_field", 32'(bus.edit_field), 32'd0);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
